// File: rtl/lab3_pkg.sv
// Shared types and constants for the lab3 exhaustive-stimulus BIST engine.
package lab3_pkg;

  localparam int unsigned N_PATTERNS = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned ERR_W      = 4;

  localparam logic [N_PATTERNS-1:0] EXP_X_DEFAULT = 8'hE8;
  localparam logic [N_PATTERNS-1:0] EXP_Y_DEFAULT = 8'h96;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } bist_state_t;

  // Result payload that persists from one completed run until the next accepted start
  typedef struct packed {
    logic [N_PATTERNS-1:0] fail_vec;
    logic [ERR_W-1:0]      err_count;
    logic                  pass;
  } bist_result_t;

endpackage

// File: rtl/lab3_bist_if.sv
// Stimulus/response and status bundle between the BIST engine and the lab3 datapath.
interface lab3_bist_if;
  import lab3_pkg::*;

  logic                  start;
  logic                  a;
  logic                  b;
  logic                  c;
  logic                  x;
  logic                  y;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [ERR_W-1:0]      err_count;
  logic [N_PATTERNS-1:0] fail_vec;

  modport master (
    input  start, x, y,
    output a, b, c, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    output start, x, y,
    input  a, b, c, busy, done, pass, err_count, fail_vec
  );

endinterface

// File: rtl/lab3_hold_timer.sv
// Per-pattern hold counter; strobes o_sample_c on the last cycle of each hold window.
module lab3_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_sample_c
);

  localparam int unsigned        CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_sample_c = i_en && (r_cnt == CNT_LAST);

  // Wraps to zero on the sample edge so each pattern gets a full window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_sample_c) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lab3_bist.sv
// Exhaustive BIST for the 3-in/2-out lab3 datapath: steps {a,b,c} through 0..7,
// samples x/y at the end of each hold window and accumulates mismatches.
module lab3_bist
  import lab3_pkg::*;
#(
  parameter int unsigned           HOLD_CYCLES = 10,
  parameter logic [N_PATTERNS-1:0] EXP_X       = EXP_X_DEFAULT,
  parameter logic [N_PATTERNS-1:0] EXP_Y       = EXP_Y_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  lab3_bist_if.master      bif
);

  bist_state_t           r_state;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_busy;
  logic                  r_done;
  bist_result_t          r_res;

  logic                  w_accept;
  logic                  w_drive;
  logic                  w_sample;
  logic                  w_mis;
  logic                  w_last;
  logic [N_PATTERNS-1:0] w_fail_next;

  assign w_accept    = (r_state == IDLE) && bif.start;
  assign w_drive     = (r_state == DRIVE);
  assign w_mis       = (bif.x != EXP_X[r_idx]) || (bif.y != EXP_Y[r_idx]);
  assign w_last      = (r_idx == IDX_W'(N_PATTERNS - 1));
  assign w_fail_next = r_res.fail_vec | (N_PATTERNS'(w_mis) << r_idx);

  lab3_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_accept),
    .i_en       (w_drive),
    .o_sample_c (w_sample)
  );

  // Control FSM plus index and result registers; r_idx doubles as the registered stimulus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_res   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bif.start) begin
            r_state <= DRIVE;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_res   <= '0;
          end
        end
        DRIVE: begin
          if (w_sample) begin
            if (w_mis) begin
              r_res.fail_vec  <= w_fail_next;
              r_res.err_count <= r_res.err_count + ERR_W'(1);
            end
            // Returning idx to zero also returns the stimulus to 000 during DONE
            if (w_last) begin
              r_state    <= DONE;
              r_idx      <= '0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_res.pass <= (w_fail_next == '0);
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bif.a         = r_idx[2];
  assign bif.b         = r_idx[1];
  assign bif.c         = r_idx[0];
  assign bif.busy      = r_busy;
  assign bif.done      = r_done;
  assign bif.pass      = r_res.pass;
  assign bif.err_count = r_res.err_count;
  assign bif.fail_vec  = r_res.fail_vec;

endmodule

// File: tb/tb_lab3_bist.sv
// Directed bench for lab3_bist: two engines (hold 10 and hold 1) each checking a
// behavioural lab3 model with selectable faults; results scored through a queue.
module tb_lab3_bist;

  typedef struct packed {
    logic [7:0] fv;
    logic [3:0] ec;
    logic       pass;
  } res_t;

  logic clk;
  logic rst_n;
  int   fault10;
  int   fault1;
  int   n_vec;
  int   n_mis;
  res_t sb[$];

  lab3_bist_if bus10 ();
  lab3_bist_if bus1 ();

  lab3_bist #(.HOLD_CYCLES(10)) u_dut10 (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bus10)
  );

  lab3_bist #(.HOLD_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full-adder datapath with optional faults: 1 y stuck-0, 2 x inverted, 3 x flipped at pattern 5
  function automatic logic [1:0] model(input int fault, input logic [2:0] p);
    logic xo;
    logic yo;
    xo = (p[2] & p[1]) | (p[2] & p[0]) | (p[1] & p[0]);
    yo = ^p;
    case (fault)
      1:       yo = 1'b0;
      2:       xo = ~xo;
      3:       if (p == 3'd5) xo = ~xo;
      default: ;
    endcase
    return {xo, yo};
  endfunction

  function automatic res_t expect_run(input int fault);
    res_t r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (model(0, 3'(i)) != model(fault, 3'(i))) begin
        r.fv[i] = 1'b1;
        r.ec    = r.ec + 4'd1;
      end
    end
    r.pass = (r.ec == 4'd0);
    return r;
  endfunction

  logic [1:0] w_xy10;
  logic [1:0] w_xy1;
  always_comb begin
    w_xy10   = model(fault10, {bus10.a, bus10.b, bus10.c});
    bus10.x  = w_xy10[1];
    bus10.y  = w_xy10[0];
    w_xy1    = model(fault1, {bus1.a, bus1.b, bus1.c});
    bus1.x   = w_xy1[1];
    bus1.y   = w_xy1[0];
  end

  function automatic logic [2:0] get_abc(input int w);
    return (w != 0) ? {bus1.a, bus1.b, bus1.c} : {bus10.a, bus10.b, bus10.c};
  endfunction
  function automatic logic get_busy(input int w);
    return (w != 0) ? bus1.busy : bus10.busy;
  endfunction
  function automatic logic get_done(input int w);
    return (w != 0) ? bus1.done : bus10.done;
  endfunction
  function automatic res_t get_res(input int w);
    res_t r;
    if (w != 0) r = {bus1.fail_vec, bus1.err_count, bus1.pass};
    else        r = {bus10.fail_vec, bus10.err_count, bus10.pass};
    return r;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w != 0) bus1.start = v;
    else        bus10.start = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input int w, input bit keep);
    set_start(w, 1'b1);
    @(negedge clk);
    if (!keep) set_start(w, 1'b0);
  endtask

  // Called one negedge after the accept edge; waits for done and scores the run
  task automatic wait_done(input int w, input int hold, input int mid_at);
    int   cyc;
    res_t exp_r;
    res_t got;
    cyc = 0;
    chk("busy_after_start", 32'(get_busy(w)), 32'd1);
    while (!get_done(w) && cyc < 8 * hold + 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == mid_at)     set_start(w, 1'b1);
      if (cyc == mid_at + 1) set_start(w, 1'b0);
      if ((cyc % hold) == (hold / 2) && cyc < 8 * hold)
        chk("abc_pattern", 32'(get_abc(w)), 32'(cyc / hold));
    end
    chk("done_cycle", 32'(cyc), 32'(8 * hold));
    chk("busy_at_done", 32'(get_busy(w)), 32'd0);
    chk("abc_at_done", 32'(get_abc(w)), 32'd0);
    exp_r = sb.pop_front();
    got   = get_res(w);
    chk("fail_vec", 32'(got.fv), 32'(exp_r.fv));
    chk("err_count", 32'(got.ec), 32'(exp_r.ec));
    chk("pass", 32'(got.pass), 32'(exp_r.pass));
    @(negedge clk);
    chk("done_one_cycle", 32'(get_done(w)), 32'd0);
  endtask

  initial begin
    int   ndone;
    res_t r;
    n_vec       = 0;
    n_mis       = 0;
    fault10     = 0;
    fault1      = 0;
    bus10.start = 1'b0;
    bus1.start  = 1'b0;
    rst_n       = 1'b0;

    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      r = get_res(w);
      chk("rst_abc", 32'(get_abc(w)), 32'd0);
      chk("rst_busy", 32'(get_busy(w)), 32'd0);
      chk("rst_done", 32'(get_done(w)), 32'd0);
      chk("rst_results", 32'(r), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Correct DUT, hold 10
    sb.push_back(expect_run(0));
    launch(0, 1'b0);
    wait_done(0, 10, -1);

    // y stuck at 0, then x inverted
    fault10 = 1;
    sb.push_back(expect_run(1));
    launch(0, 1'b0);
    wait_done(0, 10, -1);
    fault10 = 2;
    sb.push_back(expect_run(2));
    launch(0, 1'b0);
    wait_done(0, 10, -1);

    // Stray start pulse at cycle 35 must not disturb the run
    fault10 = 0;
    sb.push_back(expect_run(0));
    launch(0, 1'b0);
    wait_done(0, 10, 35);

    // start held high through DONE: y-stuck run, then immediate re-run with clean DUT
    fault10 = 1;
    sb.push_back(expect_run(1));
    launch(0, 1'b1);
    wait_done(0, 10, -1);
    chk("restart_idle_busy", 32'(get_busy(0)), 32'd0);
    @(negedge clk);
    r = get_res(0);
    chk("restart_cleared", 32'(r), 32'd0);
    fault10 = 0;
    set_start(0, 1'b0);
    sb.push_back(expect_run(0));
    wait_done(0, 10, -1);

    // Reset during pattern 3: outputs clear before the next clock edge, no done
    launch(0, 1'b0);
    repeat (35) @(negedge clk);
    chk("pre_abort_abc", 32'(get_abc(0)), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    r = get_res(0);
    chk("abort_abc", 32'(get_abc(0)), 32'd0);
    chk("abort_busy", 32'(get_busy(0)), 32'd0);
    chk("abort_results", 32'(r), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (90) begin
      @(negedge clk);
      if (get_done(0)) ndone++;
    end
    chk("no_done_after_abort", 32'(ndone), 32'd0);
    sb.push_back(expect_run(0));
    launch(0, 1'b0);
    wait_done(0, 10, -1);

    // Hold 1: correct DUT, then single x fault on pattern 5
    fault1 = 0;
    sb.push_back(expect_run(0));
    launch(1, 1'b0);
    wait_done(1, 1, -1);
    fault1 = 3;
    sb.push_back(expect_run(3));
    launch(1, 1'b0);
    wait_done(1, 1, -1);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
